// File: rtl/shared_adder_sched_if.sv
// Requester, shared-adder and response signals of the round-robin adder scheduler.
// slave = scheduler side; master = requesters, adder and response consumer.
interface shared_adder_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 22,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_last;

    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_last;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last,
        output req_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last,
        input  req_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last,
        output rsp_ready
    );
endinterface

// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one combinational W-bit adder between NREQ requesters,
// with chained multi-beat carries and a one-entry registered response stage.
module shared_adder_sched #(
    parameter int NREQ = 4,
    parameter int W    = 22,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_adder_sched_if.slave   bus
);
    localparam int             IW1    = IDW + 1;
    localparam logic [IDW:0]   NREQ_L = IW1'(NREQ);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, grant, winner, owner;
    logic           carry_q;
    logic           win_found, has_owner, space, accept;
    logic [W-1:0]   own_a, own_b;
    logic           own_cin, own_last, own_valid;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v, input int step);
        logic [IDW:0] s;
        s = {1'b0, v} + IW1'(step);
        if (s >= NREQ_L) s = s - NREQ_L;
        return s[IDW-1:0];
    endfunction

    // Cyclic search from rr_ptr; iterating downwards lets the closest index win.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_inc(rr_ptr, k)]) begin
                win_found = 1'b1;
                winner    = wrap_inc(rr_ptr, k);
            end
        end
    end

    always_comb begin
        has_owner = (state == LOCK) | win_found;
        owner     = (state == LOCK) ? grant : winner;
        own_a     = '0;
        own_b     = '0;
        own_cin   = 1'b0;
        own_last  = 1'b0;
        own_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (has_owner && owner == IDW'(i)) begin
                own_a     = bus.req_a[i*W +: W];
                own_b     = bus.req_b[i*W +: W];
                own_cin   = bus.req_cin[i];
                own_last  = bus.req_last[i];
                own_valid = bus.req_valid[i];
            end
        end
    end

    assign space  = !bus.rsp_valid | bus.rsp_ready;
    assign accept = space & own_valid;

    // The adder sees only owner state, never rsp_ready.
    assign bus.add_a   = own_a;
    assign bus.add_b   = own_b;
    assign bus.add_cin = has_owner & ((state == IDLE) ? own_cin : carry_q);

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = rst_n & space & has_owner & (owner == IDW'(i));
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) state_nx = own_last ? IDLE : LOCK;
    end

    // Response stage boundary: adder result captured one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            carry_q       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_last  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                grant         <= owner;
                carry_q       <= bus.add_cout;
                bus.rsp_valid <= 1'b1;
                bus.rsp_sum   <= bus.add_sum;
                bus.rsp_cout  <= bus.add_cout;
                bus.rsp_id    <= owner;
                bus.rsp_last  <= own_last;
                if (own_last) rr_ptr <= wrap_inc(owner, 1);
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shared_adder_sched.sv
// Bench for shared_adder_sched: vector table, directed multi-cycle sequences and a
// randomized run scored against multi-word integer arithmetic per transaction.
module tb_shared_adder_sched;
    localparam int NREQ = 4;
    localparam int W    = 22;
    localparam int IDW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    shared_adder_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();

    shared_adder_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared prefix adder.
    assign {bus.add_cout, bus.add_sum} = (W+1)'(bus.add_a) + (W+1)'(bus.add_b) + (W+1)'(bus.add_cin);

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         last;
        logic         exp_cin;
        logic [W-1:0] sum;
        logic         cout;
    } beat_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         last;
    } exp_t;

    vec_t         tbl[6];
    beat_t        chain[3];
    logic [95:0]  ta[NREQ];
    logic [95:0]  tbv[NREQ];
    int           nb[NREQ];
    int           bi[NREQ];
    bit           act[NREQ];
    bit           tcin[NREQ];
    exp_t         eq[NREQ][$];
    logic [NREQ-1:0] fired;
    int           open_id;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.req_last  = '0;
    endtask

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic last);
        bus.req_valid[id]        = 1'b1;
        bus.req_a[id*W +: W]     = a;
        bus.req_b[id*W +: W]     = b;
        bus.req_cin[id]          = cin;
        bus.req_last[id]         = last;
    endtask

    task automatic chk_rsp(input string nm, input int id, input logic [W-1:0] sum,
                           input logic cout, input logic last);
        chk({nm, "_valid"}, bus.rsp_valid, 1);
        chk({nm, "_id"},    bus.rsp_id, id);
        chk({nm, "_sum"},   bus.rsp_sum, sum);
        chk({nm, "_cout"},  bus.rsp_cout, cout);
        chk({nm, "_last"},  bus.rsp_last, last);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(3))
            0:       return '1;
            1:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    // Expected beats come from treating the whole transaction as one wide integer sum.
    task automatic new_txn(input int i);
        logic [95:0] msk, part;
        exp_t        e;
        nb[i]   = $urandom_range(1, 3);
        bi[i]   = 0;
        act[i]  = 1'b1;
        tcin[i] = 1'($urandom_range(1));
        ta[i]   = '0;
        tbv[i]  = '0;
        for (int w = 0; w < nb[i]; w++) begin
            ta[i][w*W +: W]  = pick();
            tbv[i][w*W +: W] = pick();
        end
        for (int k = 0; k < nb[i]; k++) begin
            msk    = (96'd1 << ((k + 1) * W)) - 96'd1;
            part   = (ta[i] & msk) + (tbv[i] & msk) + 96'(tcin[i]);
            e.sum  = part[k*W +: W];
            e.cout = part[(k + 1) * W];
            e.last = (k == nb[i] - 1);
            eq[i].push_back(e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        bit  busy;
        int  rid;
        exp_t e;

        tbl[0] = '{0, 22'h3FFFFF, 22'h000001, 1'b0, 22'h000000, 1'b1};
        tbl[1] = '{1, 22'h123456, 22'h0FEDCB, 1'b1, 22'h222222, 1'b0};
        tbl[2] = '{2, 22'h200000, 22'h200000, 1'b0, 22'h000000, 1'b1};
        tbl[3] = '{3, 22'h3FFFFF, 22'h3FFFFF, 1'b1, 22'h3FFFFF, 1'b1};
        tbl[4] = '{0, 22'h000000, 22'h000000, 1'b1, 22'h000001, 1'b0};
        tbl[5] = '{2, 22'h155555, 22'h2AAAAA, 1'b0, 22'h3FFFFF, 1'b0};

        chain[0] = '{22'h3FFFFF, 22'h0, 1'b1, 1'b0, 1'b1, 22'h0, 1'b1};
        chain[1] = '{22'h3FFFFF, 22'h0, 1'b0, 1'b0, 1'b1, 22'h0, 1'b1};
        chain[2] = '{22'h000000, 22'h0, 1'b0, 1'b1, 1'b1, 22'h1, 1'b0};

        // Reset state, with requests pending to show req_ready is held low.
        idle_inputs();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0101;
        #12;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_sum",   bus.rsp_sum, 0);
        chk("rst_rsp_cout",  bus.rsp_cout, 0);
        chk("rst_rsp_id",    bus.rsp_id, 0);
        chk("rst_rsp_last",  bus.rsp_last, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Round robin with all requesters holding single-beat requests.
        for (int i = 0; i < NREQ; i++) drive(i, W'(i + 1), 22'h0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rr_ready", bus.req_ready, 64'd1 << (c % NREQ));
            tick();
            chk_rsp("rr_rsp", c % NREQ, W'((c % NREQ) + 1), 1'b0, 1'b1);
        end
        idle_inputs();
        tick();
        chk("rr_drain_valid", bus.rsp_valid, 0);

        // Single-beat vector table.
        for (int v = 0; v < 6; v++) begin
            idle_inputs();
            drive(tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].cin, 1'b1);
            #1;
            chk("tbl_ready", bus.req_ready, 64'd1 << tbl[v].id);
            chk("tbl_add_a", bus.add_a, tbl[v].a);
            chk("tbl_add_cin", bus.add_cin, tbl[v].cin);
            tick();
            chk_rsp("tbl_rsp", tbl[v].id, tbl[v].sum, tbl[v].cout, 1'b1);
        end
        idle_inputs();
        tick();

        // Three-beat chained add on requester 2.
        for (int k = 0; k < 3; k++) begin
            drive(2, chain[k].a, chain[k].b, chain[k].cin, chain[k].last);
            #1;
            chk("chain_ready", bus.req_ready, 4'b0100);
            chk("chain_add_cin", bus.add_cin, chain[k].exp_cin);
            tick();
            chk_rsp("chain_rsp", 2, chain[k].sum, chain[k].cout, chain[k].last);
        end
        idle_inputs();
        tick();

        // Owner bubble: requester 1 locked, requester 3 waiting.
        drive(1, 22'h3FFFFF, 22'h000001, 1'b0, 1'b0);
        #1;
        chk("lock_first_ready", bus.req_ready, 4'b0010);
        tick();
        chk_rsp("lock_first_rsp", 1, 22'h0, 1'b1, 1'b0);
        bus.req_valid[1] = 1'b0;
        drive(3, 22'h000007, 22'h0, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("lock_bubble_ready", bus.req_ready, 4'b0010);
            tick();
            chk("lock_bubble_rsp_valid", bus.rsp_valid, 0);
        end
        drive(1, 22'h0, 22'h0, 1'b0, 1'b1);
        #1;
        chk("lock_resume_ready", bus.req_ready, 4'b0010);
        chk("lock_resume_cin", bus.add_cin, 1);
        tick();
        chk_rsp("lock_resume_rsp", 1, 22'h1, 1'b0, 1'b1);
        bus.req_valid[1] = 1'b0;
        #1;
        chk("lock_next_ready", bus.req_ready, 4'b1000);
        tick();
        chk_rsp("lock_next_rsp", 3, 22'h7, 1'b0, 1'b1);
        idle_inputs();
        tick();

        // Response backpressure.
        bus.rsp_ready = 1'b0;
        drive(0, 22'h00ABCD, 22'h000011, 1'b0, 1'b1);
        #1;
        chk("bp_first_ready", bus.req_ready, 4'b0001);
        tick();
        chk_rsp("bp_first_rsp", 0, 22'h00ABDE, 1'b0, 1'b1);
        drive(0, 22'h000100, 22'h000200, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_stall_ready", bus.req_ready, 0);
            tick();
            chk_rsp("bp_stall_rsp", 0, 22'h00ABDE, 1'b0, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.req_ready, 4'b0001);
        tick();
        chk_rsp("bp_refill_rsp", 0, 22'h000300, 1'b0, 1'b1);
        idle_inputs();
        tick();

        // Reset pulse in the middle of a chained transaction.
        drive(2, 22'h3FFFFF, 22'h000002, 1'b1, 1'b0);
        #1;
        chk("mrst_b1_ready", bus.req_ready, 4'b0100);
        tick();
        chk_rsp("mrst_b1_rsp", 2, 22'h000002, 1'b1, 1'b0);
        drive(2, 22'h3FFFFF, 22'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", bus.req_ready, 0);
        chk("mrst_rsp_valid", bus.rsp_valid, 0);
        chk("mrst_rsp_sum",   bus.rsp_sum, 0);
        chk("mrst_rsp_cout",  bus.rsp_cout, 0);
        chk("mrst_rsp_id",    bus.rsp_id, 0);
        idle_inputs();
        drive(0, 22'h000005, 22'h000006, 1'b1, 1'b1);
        drive(2, 22'h000001, 22'h000001, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_win_ready", bus.req_ready, 4'b0001);
        chk("mrst_win_cin", bus.add_cin, 1);
        chk("mrst_win_a", bus.add_a, 22'h000005);
        tick();
        chk_rsp("mrst_win_rsp", 0, 22'h00000C, 1'b0, 1'b1);
        bus.req_valid[0] = 1'b0;
        #1;
        chk("mrst_restart_ready", bus.req_ready, 4'b0100);
        chk("mrst_restart_cin", bus.add_cin, 0);
        tick();
        chk_rsp("mrst_restart_rsp", 2, 22'h000002, 1'b0, 1'b1);
        idle_inputs();
        tick();

        // Randomized traffic with bubbles, backpressure and multi-beat transactions.
        fired   = '0;
        open_id = -1;
        cyc     = 0;
        for (int i = 0; i < NREQ; i++) act[i] = 1'b0;
        while (1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (fired[i]) begin
                    bi[i]++;
                    if (bi[i] == nb[i]) act[i] = 1'b0;
                end
            end
            busy = 1'b0;
            for (int i = 0; i < NREQ; i++) busy |= act[i] | (eq[i].size() != 0);
            if (cyc >= 3000 && !busy) break;
            if (cyc >= 3600) begin
                chk("rnd_drain_timeout", 1, 0);
                break;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!act[i] && cyc < 3000 && $urandom_range(3) == 0) new_txn(i);
                if (act[i]) begin
                    bus.req_valid[i]     = ($urandom_range(3) != 0);
                    bus.req_a[i*W +: W]  = ta[i][bi[i]*W +: W];
                    bus.req_b[i*W +: W]  = tbv[i][bi[i]*W +: W];
                    bus.req_cin[i]       = (bi[i] == 0) ? tcin[i] : ~tcin[i];
                    bus.req_last[i]      = (bi[i] == nb[i] - 1);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(2) != 0);
            #1;
            chk("rnd_onehot_ready", ($countones(bus.req_ready) <= 1), 1);
            fired = bus.req_valid & bus.req_ready;
            if (bus.rsp_valid && bus.rsp_ready) begin
                rid = int'(bus.rsp_id);
                if (open_id >= 0) chk("rnd_atomic_id", rid, open_id);
                if (eq[rid].size() == 0) begin
                    chk("rnd_unexpected_rsp", rid, 64'hFFFF);
                end else begin
                    e = eq[rid].pop_front();
                    chk("rnd_sum",  bus.rsp_sum, e.sum);
                    chk("rnd_cout", bus.rsp_cout, e.cout);
                    chk("rnd_last", bus.rsp_last, e.last);
                end
                open_id = bus.rsp_last ? -1 : rid;
            end
            tick();
            cyc++;
        end
        for (int i = 0; i < NREQ; i++) chk("rnd_leftover", eq[i].size(), 0);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shared_adder_sched.md
Name: shared_adder_sched

Overview:
- Round-robin scheduler that shares one combinational 22-bit prefix adder (Ling/Knowles class) between NREQ requesters.
- Supports multi-word (chained) additions: successive beats of one transaction carry the previous beat's cout into the next beat's cin.
- Sits between requester valid/ready streams and the shared adder instance.
- Results come from a one-entry registered response stage tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 22, adder operand width; must match the shared adder
- IDW, 2, requester id width; must be at least clog2(NREQ)

Ports:
- clk  in  1  clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester beat valid
- req_ready  out  NREQ  per-requester beat accepted (valid&ready)
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W]
- req_b  in  NREQ*W  operand B; same packing as req_a
- req_cin  in  NREQ  carry-in; used on the first beat of a transaction only
- req_last  in  NREQ  marks the final beat of a transaction
- add_a  out  W  to shared adder a
- add_b  out  W  to shared adder b
- add_cin  out  1  to shared adder cin
- add_sum  in  W  from shared adder sum (combinational)
- add_cout  in  1  from shared adder cout
- rsp_valid  out  1  response register full
- rsp_ready  in  1  consumer accepts response
- rsp_sum  out  W  registered sum
- rsp_cout  out  1  registered carry-out of that beat
- rsp_id  out  IDW  requester that issued the beat
- rsp_last  out  1  final beat of transaction

Behaviour:
- Reset values (rst_n low, async):
  - FSM=IDLE, rr_ptr=0, carry_q=0, grant=0
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_last=0
  - req_ready=0
- States:
  - IDLE: no owner.
  - LOCK: owner = grant; held until the owner's last beat is accepted.
- IDLE arbitration:
  - Among req_valid, pick the first index at or after rr_ptr, searching cyclically.
  - Grant is combinational in the same cycle; a beat may be accepted in the arbitration cycle itself.
- Acceptance:
  - space = !rsp_valid | rsp_ready.
  - req_ready[i] = space & (i == current owner, or the IDLE winner).
  - All other req_ready bits are 0.
- Adder drive:
  - add_a/add_b = owner's operands.
  - add_cin = req_cin[owner] on the first beat, else carry_q.
  - With no owner, add_a/add_b/add_cin = 0.
- On an accepted beat (latency 1):
  - rsp_sum <= add_sum, rsp_cout <= add_cout, rsp_id <= owner, rsp_last <= req_last[owner], rsp_valid <= 1.
  - carry_q <= add_cout.
- Transaction end:
  - An accepted beat with req_last=1 moves the FSM to IDLE and sets rr_ptr <= owner+1 (mod NREQ).
  - Otherwise the FSM is, or goes to, LOCK.
- Response register:
  - If rsp_ready & rsp_valid and no new beat is accepted, rsp_valid <= 0.
  - Fill and drain in the same cycle gives back-to-back throughput of 1 beat/cycle.
- Owner drops req_valid inside LOCK: bubble, no re-arbitration, carry_q held.
- Single-beat transaction (req_last on the first beat): full arbitration cycle, no lock residue.
- Overflow: a W-bit wrap is reported through rsp_cout only; sums are never saturated.
- rsp_ready low with rsp_valid high: req_ready is all 0; response fields stay stable until taken.
- Reset mid-transaction: owner and partial carry are discarded; the requester must restart.
- Requirements on requesters:
  - A requester must not change its operands while valid & !ready.
  - A requester may not abandon a transaction before its last beat.
- Structure: no combinational path from rsp_ready to add_*; rsp_ready may only gate req_ready.

Test Plan:
- Single beat, requester 0: a=0x3FFFFF, b=1, cin=0, last=1 -> next cycle rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_last=1; rr_ptr=1.
- Chained 3-beat add, requester 2: beats (0x3FFFFF,0,cin=1), (0x3FFFFF,0), (0,0,last) -> sums 0,0,1; couts 1,1,0; req_cin ignored on beats 2-3.
- All 4 requesters hold single-beat requests continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one response per cycle.
- Requester 1 locked mid-transaction, requester 3 valid; requester 1 drops valid for 2 cycles -> req_ready[3] stays 0, carry_q retained, the resumed beat uses it.
- rsp_ready=0 for 3 cycles with rsp_valid=1 -> req_ready=0, rsp fields stable; on rsp_ready=1, a fill and drain in the same cycle.
- rst_n pulsed low during beat 2 of 3 -> all outputs at reset values immediately; after release requester 0 wins (rr_ptr=0) and its first beat uses req_cin.
